adc_acq_sched: RTL and testbench
================================

Name: adc_acq_sched

Overview:
Acquisition scheduler in the ADC clock domain. It arbitrates capture requests from several readout sequencers and drives one shared double-banked ADC waveform buffer: it issues the single-cycle trigger and the waveform length, tracks capture progress and enforces a post-capture holdoff. It sits between the per-qubit sequencers and the ADC buffer, and keeps status counters for the local bus.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 12, waveform length width in samples (4 samples per ADC word)
HW, 8, holdoff counter width

Ports:
adc_phy_clk  input  1  sole clock
reset  input  1  asynchronous, active-high reset
enable  input  1  permits new grants; an in-flight capture always completes
req  input  NREQ  per-requester single-cycle capture request pulse
req_len  input  NREQ*AW  per-requester length in samples, slice i = [i*AW +: AW], sampled when the request pulse arrives
adc_phy_val  input  1  ADC word valid
holdoff  input  HW  idle cycles required after each capture
adc_trigger  output  1  single-cycle trigger to the buffer
wfm_len  output  AW  length to the buffer, stable from trigger until done
grant  output  NREQ  one-hot pulse, coincident with adc_trigger
active_id  output  3  index of the requester being served
busy  output  1  high from trigger until holdoff expires
done  output  1  single-cycle pulse on the last captured word
cap_cnt  output  16  completed captures, wraps
drop_cnt  output  16  dropped or rejected requests, saturates at 0xFFFF

Behaviour:
- Reset: all outputs 0, pending bits 0, stored lengths 0, RR pointer 0, state IDLE.
- Request latch: on req[i], set pend[i] and store len[i] = req_len slice i.
  - If pend[i] is already set, or the requester is the one being served, the request is dropped and drop_cnt increments.
  - If req_len[AW-1:2] == 0, the request is rejected: pend stays clear and drop_cnt increments.
  - Several drops in one cycle add the total number of drops to drop_cnt, saturating.
- Arbitration: round-robin. Search starts at the RR pointer; the winner is the lowest index >= pointer (with wrap) whose pend bit is set. After a grant the pointer becomes winner+1 mod NREQ.
- FSM states:
  - IDLE: when enable=1 and any pend bit is set, in the next cycle pulse adc_trigger and grant[w], load wfm_len=len[w] and active_id=w, clear pend[w], set busy, go to CAPT. Latency from a req pulse in IDLE to adc_trigger is 2 cycles.
  - CAPT: the word counter starts at 0 on the trigger cycle and increments on each adc_phy_val after the trigger cycle. When the counter equals wfm_len[AW-1:2]-1 with adc_phy_val=1, pulse done and increment cap_cnt. Then go to HOLD if holdoff != 0, otherwise go to IDLE and clear busy.
  - HOLD: down-counter loaded with holdoff, decrements each cycle; at 1, go to IDLE and clear busy. This gives exactly `holdoff` busy cycles after done.
- Cycles with adc_phy_val=0 stall the count; there is no timeout.
- wfm_len and active_id hold their last values in IDLE.
- A request that arrives in the same cycle as the grant to the same index is dropped, because that index is now the one being served.
- enable going low in CAPT or HOLD does not abort; pending bits are retained and are served after enable returns.
- Counter width: the capture word counter is AW-2 bits. The maximum length, 2^AW-4 samples, must complete without wrap.
- The low two bits of req_len are ignored for counting but are passed through on wfm_len.
- Reset asserted mid-capture: immediate return to IDLE, no done pulse, counters cleared.

Test Plan:
- Single request, holdoff=0: req[1] with len 64 and continuous val -> trigger/grant[1] 2 cycles later; done on the 16th val after the trigger; busy for 17 cycles; cap_cnt=1.
- Round-robin: req[0], req[2] and req[3] in the same cycle with pointer 0 -> grant order 0, 2, 3. Then req[0] and req[3] together -> grant 0 first (pointer wrapped to 0).
- Drops: req[2] twice while pending, plus one request with len 3 -> drop_cnt=2, only one capture for requester 2.
- Holdoff=5, len 16, val toggling every other cycle -> done after 4 vals; busy falls 5 cycles after done; a queued request triggers on the cycle after busy falls.
- Enable low in the middle of CAPT with req[1] pending -> the capture completes, no new trigger; enable high -> trigger 1 cycle later.
- Reset asserted during CAPT -> trigger, busy, done and counters go to 0 asynchronously; a fresh request afterwards captures normally.

Source files
------------

// File: rtl/adc_acq_sched_if.sv
// adc_acq_sched_if: sequencer-request and buffer-control bundle
// shared between the readout sequencers and the acquisition scheduler.
interface adc_acq_sched_if #(
   parameter int NREQ = 4,
   parameter int AW   = 12,
   parameter int HW   = 8
);
   logic                 enable;
   logic [NREQ-1:0]      req;
   logic [NREQ*AW-1:0]   req_len;
   logic                 adc_phy_val;
   logic [HW-1:0]        holdoff;
   logic                 adc_trigger;
   logic [AW-1:0]        wfm_len;
   logic [NREQ-1:0]      grant;
   logic [2:0]           active_id;
   logic                 busy;
   logic                 done;
   logic [15:0]          cap_cnt;
   logic [15:0]          drop_cnt;

   modport master (
      output enable, req, req_len, adc_phy_val, holdoff,
      input  adc_trigger, wfm_len, grant, active_id,
      input  busy, done, cap_cnt, drop_cnt
   );

   modport slave (
      input  enable, req, req_len, adc_phy_val, holdoff,
      output adc_trigger, wfm_len, grant, active_id,
      output busy, done, cap_cnt, drop_cnt
   );
endinterface

// File: rtl/adc_acq_sched.sv
// adc_acq_sched: round-robin capture scheduler for a shared ADC buffer;
// issues trigger/length, counts captured words, enforces holdoff.
module adc_acq_sched #(
   parameter int NREQ = 4,
   parameter int AW   = 12,
   parameter int HW   = 8
) (
   input  logic           adc_phy_clk,
   input  logic           reset,
   adc_acq_sched_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] pend_q, pend_d;
   logic [AW-1:0]   len_q [NREQ];
   logic [AW-1:0]   len_d [NREQ];
   logic [IW-1:0]   rr_q, rr_d;
   logic [IW-1:0]   id_q, id_d;
   logic [AW-1:0]   wlen_q, wlen_d;
   logic [AW-3:0]   wcnt_q, wcnt_d;
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic            trig_q, trig_d;
   logic [15:0]     cap_q, cap_d;
   logic [15:0]     drop_q, drop_d;

   logic            busy;
   logic            done;
   logic            grant_now;
   logic            found;
   logic [IW-1:0]   win;
   logic [IW-1:0]   idx;
   logic [3:0]      ndrop;
   logic [16:0]     drop_sum;

   assign busy = (state_q != IDLE);

   // First pending index at or after the pointer, with wrap.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IW'((32'(rr_q) + k) % NREQ);
         if (!found && pend_q[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      trig_d    = 1'b0;
      rr_d      = rr_q;
      id_d      = id_q;
      wlen_d    = wlen_q;
      wcnt_d    = wcnt_q;
      hcnt_d    = hcnt_q;
      cap_d     = cap_q;
      done      = 1'b0;
      grant_now = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.enable && found) begin
               grant_now = 1'b1;
               trig_d    = 1'b1;
               id_d      = win;
               wlen_d    = len_q[win];
               wcnt_d    = '0;
               rr_d      = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
               state_d   = CAPT;
            end
         end
         CAPT: begin
            // The trigger cycle itself never counts a word.
            if (!trig_q && bus.adc_phy_val) begin
               if (wcnt_q == wlen_q[AW-1:2] - 1'b1) begin
                  done  = 1'b1;
                  cap_d = cap_q + 16'd1;
                  if (bus.holdoff != '0) begin
                     hcnt_d  = bus.holdoff;
                     state_d = HOLD;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            hcnt_d = hcnt_q - 1'b1;
            if (hcnt_q == HW'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pend_d = pend_q;
      len_d  = len_q;
      ndrop  = '0;
      if (grant_now) pend_d[win] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req[i]) begin
            if (pend_q[i] || (busy && id_q == IW'(i)) ||
                bus.req_len[i*AW+2 +: AW-2] == '0) begin
               ndrop = ndrop + 4'd1;
            end else begin
               pend_d[i] = 1'b1;
               len_d[i]  = bus.req_len[i*AW +: AW];
            end
         end
      end
      drop_sum = {1'b0, drop_q} + 17'(ndrop);
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge adc_phy_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= '0;
         for (int i = 0; i < NREQ; i++) len_q[i] <= '0;
         rr_q    <= '0;
         id_q    <= '0;
         wlen_q  <= '0;
         wcnt_q  <= '0;
         hcnt_q  <= '0;
         trig_q  <= 1'b0;
         cap_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         len_q   <= len_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         wlen_q  <= wlen_d;
         wcnt_q  <= wcnt_d;
         hcnt_q  <= hcnt_d;
         trig_q  <= trig_d;
         cap_q   <= cap_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.adc_trigger = trig_q;
   assign bus.grant       = trig_q ? (NREQ'(1) << id_q) : '0;
   assign bus.active_id   = 3'(id_q);
   assign bus.wfm_len     = wlen_q;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.cap_cnt     = cap_q;
   assign bus.drop_cnt    = drop_q;
endmodule

// File: tb/tb_adc_acq_sched.sv
// tb_adc_acq_sched: directed and random stimulus against a
// transaction-level reference model of the acquisition scheduler.
module tb_adc_acq_sched;
   localparam int NREQ = 4;
   localparam int AW   = 12;
   localparam int HW   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   adc_acq_sched_if #(.NREQ(NREQ), .AW(AW), .HW(HW)) bus ();

   adc_acq_sched #(.NREQ(NREQ), .AW(AW), .HW(HW)) dut (
      .adc_phy_clk (clk),
      .reset       (rst),
      .bus         (bus)
   );

   // Reference model: pending set, stored lengths, pointer, and the
   // remaining words / holdoff cycles of the capture in service.
   bit m_pend [NREQ];
   int m_len  [NREQ];
   int m_ptr, m_id, m_wlen, m_left, m_hold, m_cap, m_drop;
   bit m_serv, m_first;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < NREQ; i++) begin
         m_pend[i] = 1'b0;
         m_len[i]  = 0;
      end
      m_ptr = 0; m_id = 0; m_wlen = 0; m_left = 0;
      m_hold = 0; m_cap = 0; m_drop = 0;
      m_serv = 1'b0; m_first = 1'b0;
   endfunction

   function automatic logic [NREQ*AW-1:0] mk(input int a0, input int a1,
                                             input int a2, input int a3);
      logic [NREQ*AW-1:0] v;
      v = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
      return v;
   endfunction

   // One clock: apply inputs, compare against the model, advance both.
   task automatic step(input logic [NREQ-1:0] r,
                       input logic [NREQ*AW-1:0] l,
                       input bit v, input bit en, input int h);
      bit busy_e, done_e;
      int w;
      bus.req         = r;
      bus.req_len     = l;
      bus.adc_phy_val = v;
      bus.enable      = en;
      bus.holdoff     = HW'(h);
      #3;
      busy_e = m_serv || (m_hold > 0);
      done_e = m_serv && !m_first && v && (m_left == 1);
      chk("trigger",   32'(bus.adc_trigger), 32'(m_first));
      chk("grant",     32'(bus.grant), m_first ? (32'd1 << m_id) : 32'd0);
      chk("busy",      32'(bus.busy), 32'(busy_e));
      chk("done",      32'(bus.done), 32'(done_e));
      chk("active_id", 32'(bus.active_id), m_id);
      chk("wfm_len",   32'(bus.wfm_len), m_wlen);
      chk("cap_cnt",   32'(bus.cap_cnt), m_cap);
      chk("drop_cnt",  32'(bus.drop_cnt), m_drop);
      w = -1;
      if (!busy_e && en) begin
         for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (w < 0 && m_pend[j]) w = j;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (r[i]) begin
            int li;
            li = int'(l[i*AW +: AW]);
            if (m_pend[i] || (busy_e && m_id == i) || li < 4) begin
               if (m_drop < 65535) m_drop++;
            end else begin
               m_pend[i] = 1'b1;
               m_len[i]  = li;
            end
         end
      end
      if (w >= 0) begin
         m_pend[w] = 1'b0;
         m_serv    = 1'b1;
         m_first   = 1'b1;
         m_id      = w;
         m_wlen    = m_len[w];
         m_left    = m_len[w] / 4;
         m_ptr     = (w + 1) % NREQ;
      end else if (m_serv) begin
         if (!m_first && v) begin
            m_left--;
            if (m_left == 0) begin
               m_serv = 1'b0;
               m_cap  = (m_cap + 1) % 65536;
               m_hold = h;
            end
         end
         m_first = 1'b0;
      end else if (m_hold > 0) begin
         m_hold--;
      end
      @(posedge clk);
      #1;
   endtask

   // vmode: 0 = val low, 1 = val high, 2 = val every other cycle
   task automatic idle(input int n, input int vmode, input bit en,
                       input int h);
      for (int c = 0; c < n; c++) begin
         step('0, '0, (vmode == 1) || (vmode == 2 && c % 2 == 1), en, h);
      end
   endtask

   task automatic zero_chk(input string tag);
      chk({tag, "_trig"}, 32'(bus.adc_trigger), 0);
      chk({tag, "_grant"}, 32'(bus.grant), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_cap"}, 32'(bus.cap_cnt), 0);
      chk({tag, "_drop"}, 32'(bus.drop_cnt), 0);
   endtask

   task automatic mid_reset();
      bus.req = '0;
      #1;
      rst = 1'b1;
      #1;
      zero_chk("async_rst");
      m_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ*AW-1:0] L;
      bit                 v;
      int                 h;
      bus.enable      = 1'b0;
      bus.req         = '0;
      bus.req_len     = '0;
      bus.adc_phy_val = 1'b0;
      bus.holdoff     = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      zero_chk("reset");
      chk("reset_len", 32'(bus.wfm_len), 0);
      rst = 1'b0;

      // Single request, no holdoff.
      step(4'b0010, mk(0, 64, 0, 0), 1'b1, 1'b1, 0);
      idle(20, 1, 1'b1, 0);
      chk("single_cap", 32'(bus.cap_cnt), 1);

      // Round-robin ordering, then pointer wrap.
      step(4'b1101, mk(16, 0, 16, 16), 1'b1, 1'b1, 0);
      idle(30, 1, 1'b1, 0);
      step(4'b1001, mk(16, 0, 0, 20), 1'b1, 1'b1, 0);
      idle(20, 1, 1'b1, 0);

      // Holdoff with a queued second requester.
      step(4'b0001, mk(16, 0, 0, 0), 1'b1, 1'b1, 5);
      step(4'b1000, mk(0, 0, 0, 16), 1'b0, 1'b1, 5);
      idle(40, 2, 1'b1, 5);

      // Enable dropped mid-capture with another request pending.
      step(4'b0100, mk(0, 0, 32, 0), 1'b1, 1'b1, 0);
      idle(3, 1, 1'b1, 0);
      step(4'b0010, mk(0, 17, 0, 0), 1'b1, 1'b0, 0);
      idle(15, 1, 1'b0, 0);
      idle(12, 1, 1'b1, 0);

      // Duplicate while pending, and a too-short request.
      step(4'b0100, mk(0, 0, 16, 0), 1'b1, 1'b0, 0);
      step(4'b0100, mk(0, 0, 40, 0), 1'b1, 1'b0, 0);
      step(4'b0010, mk(0, 3, 0, 0), 1'b1, 1'b0, 0);
      idle(2, 1, 1'b0, 0);
      chk("drops", 32'(bus.drop_cnt), 2);
      idle(10, 1, 1'b1, 0);

      // Maximum word count, low length bits passed through.
      step(4'b1000, mk(0, 0, 0, 4095), 1'b1, 1'b1, 0);
      idle(1030, 1, 1'b1, 0);

      // Reset in the middle of a capture, then a fresh capture.
      step(4'b0001, mk(200, 0, 0, 0), 1'b1, 1'b1, 3);
      idle(10, 1, 1'b1, 3);
      mid_reset();
      step(4'b0001, mk(16, 0, 0, 0), 1'b1, 1'b1, 0);
      idle(10, 1, 1'b1, 0);
      chk("post_rst_cap", 32'(bus.cap_cnt), 1);

      // Random traffic.
      h = 0;
      for (int c = 0; c < 3000; c++) begin
         logic [NREQ-1:0] r;
         if (c % 200 == 0) h = $urandom_range(0, 6);
         for (int i = 0; i < NREQ; i++) begin
            r[i] = ($urandom_range(0, 7) == 0);
            L[i*AW +: AW] = ($urandom_range(0, 15) == 0) ?
                            AW'($urandom_range(0, 3)) :
                            AW'($urandom_range(4, 120));
         end
         v = ($urandom_range(0, 3) != 0);
         step(r, L, v, ($urandom_range(0, 9) != 0), h);
      end

      // Drop counter saturation with four drops per cycle.
      for (int c = 0; c < 16400; c++) begin
         step(4'b1111, '0, 1'b1, 1'b1, 0);
      end
      chk("drop_sat", 32'(bus.drop_cnt), 32'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
